// File: rtl/keys_ctrl_pkg.sv
// keys_pkg: shared types and helpers for the front-panel key controller.
//   key_act_t  - the single key action selected in a cycle (after lock/priority)
//   hold_st_t  - states of the increment/decrement hold-to-repeat FSM
//   KEY_*      - bit index of each key inside the 4-bit key vectors
//   next_set_up / next_set_dn - next set bit of a position mask, with wrap
package keys_pkg;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_EDIT,
    ACT_SWI,
    ACT_PLUS,
    ACT_MINUS
  } key_act_t;

  typedef enum logic [1:0] {
    K_IDLE,
    K_HELD,
    K_REPEAT
  } hold_st_t;

  localparam int KEY_PLUS  = 0;
  localparam int KEY_MINUS = 1;
  localparam int KEY_EDIT  = 2;
  localparam int KEY_SWI   = 3;

  // Widest position mask the helpers handle; narrower masks are zero-extended.
  localparam int MAX_POS = 32;
  typedef logic [MAX_POS-1:0] pos_mask_t;

  // Next set bit strictly after pos (ascending, wrapping within n bits).
  // The last candidate is pos itself, so a single-bit mask returns pos,
  // and an empty mask also returns pos. Calling with pos = n-1 yields the
  // lowest set bit.
  function automatic int next_set_up(input pos_mask_t mask, input int n, input int pos);
    logic       found;
    int         idx;
    logic [4:0] sel;
    found       = 1'b0;
    next_set_up = pos;
    for (int i = 1; i <= MAX_POS; i++) begin
      if (i <= n && !found) begin
        idx = (pos + i) % n;
        sel = idx[4:0];
        if (mask[sel]) begin
          found       = 1'b1;
          next_set_up = idx;
        end
      end
    end
  endfunction

  // Next set bit strictly before pos (descending, wrapping within n bits).
  function automatic int next_set_dn(input pos_mask_t mask, input int n, input int pos);
    logic       found;
    int         idx;
    logic [4:0] sel;
    found       = 1'b0;
    next_set_dn = pos;
    for (int i = 1; i <= MAX_POS; i++) begin
      if (i <= n && !found) begin
        idx = (pos + n - i) % n;
        sel = idx[4:0];
        if (mask[sel]) begin
          found       = 1'b1;
          next_set_dn = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/keys_ctrl_if.sv
// keys_ctrl_if: board-side bundle of the key controller.
//   KeyPlus/KeyMinus/KeyEdit/KeySwi - raw active-low keys (asynchronous)
//   mode12t24, swi_reverse          - layout / cursor-direction selects
//   edit_mode, screen, edit_pos     - controller state for the display mux
//   inc_pulse, dec_pulse            - one-cycle adjust strobes to the counters
// slave modport: the controller; master modport: whoever drives the keys.
interface keys_ctrl_if #(
  parameter int SCR_W = 2,
  parameter int POS_W = 3
);
  logic             KeyPlus;
  logic             KeyMinus;
  logic             KeyEdit;
  logic             KeySwi;
  logic             mode12t24;
  logic             swi_reverse;
  logic             edit_mode;
  logic [SCR_W-1:0] screen;
  logic [POS_W-1:0] edit_pos;
  logic             inc_pulse;
  logic             dec_pulse;

  modport master (
    output KeyPlus, KeyMinus, KeyEdit, KeySwi, mode12t24, swi_reverse,
    input  edit_mode, screen, edit_pos, inc_pulse, dec_pulse
  );

  modport slave (
    input  KeyPlus, KeyMinus, KeyEdit, KeySwi, mode12t24, swi_reverse,
    output edit_mode, screen, edit_pos, inc_pulse, dec_pulse
  );
endinterface

// File: rtl/keys_ctrl_filter.sv
// key_filter: 2-flop synchroniser plus debounce for one active-low key.
//   clk, reset - clock and asynchronous active-high reset
//   key_n_i    - raw key level (active-low, asynchronous)
//   level_o    - debounced level (1 = released)
//   press_o    - one-cycle press event on the debounced 1->0 edge
// The debounced level moves only after DEB_CYCLES consecutive synchronised
// samples disagree with it, giving 2 + DEB_CYCLES cycles from raw to filtered.
module key_filter #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic          s1_q, s2_q;
  logic          filt_q, filt_prev_q;
  logic          armed_q;
  logic [1:0]    fill_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      armed_q     <= 1'b0;
      fill_q      <= 2'b00;
      cnt_q       <= '0;
    end else begin
      s1_q        <= key_n_i;
      s2_q        <= s1_q;
      fill_q      <= {fill_q[0], 1'b1};
      filt_prev_q <= filt_q;
      // Arm only after a real (post-reset) sample shows the key released, so
      // a key held through reset cannot generate a press.
      if (fill_q[1] && s2_q && filt_q) armed_q <= 1'b1;
      if (s2_q != filt_q) begin
        if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          filt_q <= s2_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = filt_q;
  assign press_o = armed_q & filt_prev_q & ~filt_q;

endmodule

// File: rtl/keys_ctrl.sv
// keys_ctrl: front-panel key controller for the clock/timer display.
//   clk, reset - single clock (rising edge), asynchronous active-high reset
//   bus        - keys_ctrl_if.slave: raw keys, mode12t24, swi_reverse in;
//                edit_mode, screen, edit_pos, inc_pulse, dec_pulse out
// Debounces the four keys, applies single-key lock and priority
// (Edit > Swi > Plus > Minus), tracks screen / edit mode / cursor over
// per-screen editable masks and generates hold-to-repeat adjust strobes.
module keys_ctrl
  import keys_pkg::*;
#(
  parameter int                             NUM_SCREENS   = 3,
  parameter int                             NUM_POS       = 8,
  parameter logic [NUM_SCREENS*NUM_POS-1:0] POS_MASK      = {8'b00110101, 8'b00011100, 8'b00111111},
  parameter logic [NUM_POS-1:0]             POS_MASK12    = 8'b10111101,
  parameter int                             DEB_CYCLES    = 4,
  parameter int                             HOLD_CYCLES   = 500,
  parameter int                             REPEAT_CYCLES = 100,
  parameter int                             IDLE_TIMEOUT  = 0
) (
  input logic        clk,
  input logic        reset,
  keys_ctrl_if.slave bus
);
  localparam int SCR_W = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1;
  localparam int POS_W = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
  localparam int HMAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HCW   = (HMAX > 2) ? $clog2(HMAX) : 1;
  localparam int ICW   = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;

  logic [3:0]         raw_n, lvl, prs;
  logic               held;
  key_act_t           act;
  logic [NUM_POS-1:0] mask_act;
  pos_mask_t          mask_ext;
  logic [POS_W-1:0]   first_pos, up_pos, dn_pos;
  logic               hold_down;
  logic               timeout_hit;

  logic               edit_q;
  logic [SCR_W-1:0]   screen_q;
  logic [POS_W-1:0]   pos_q;
  logic               inc_q, dec_q;
  hold_st_t           hold_st_q;
  logic               hold_plus_q;
  logic [HCW-1:0]     hold_cnt_q;
  logic [ICW-1:0]     idle_cnt_q;

  assign raw_n = {bus.KeySwi, bus.KeyEdit, bus.KeyMinus, bus.KeyPlus};

  for (genvar k = 0; k < 4; k++) begin : g_filt
    key_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt (
      .clk     (clk),
      .reset   (reset),
      .key_n_i (raw_n[k]),
      .level_o (lvl[k]),
      .press_o (prs[k])
    );
  end

  // A key counts as blocking when it is down but not pressing this cycle;
  // keys pressing together are then resolved purely by priority.
  always_comb begin
    held = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!lvl[k] && !prs[k]) held = 1'b1;
    end
    act = ACT_NONE;
    if (!held) begin
      if (prs[KEY_EDIT])       act = ACT_EDIT;
      else if (prs[KEY_SWI])   act = ACT_SWI;
      else if (prs[KEY_PLUS])  act = ACT_PLUS;
      else if (prs[KEY_MINUS]) act = ACT_MINUS;
    end
  end

  always_comb begin
    mask_act = POS_MASK[int'(screen_q)*NUM_POS +: NUM_POS];
    if (screen_q == '0 && bus.mode12t24) mask_act = POS_MASK12;
    mask_ext = '0;
    mask_ext[NUM_POS-1:0] = mask_act;
    first_pos = POS_W'(next_set_up(mask_ext, NUM_POS, NUM_POS - 1));
    up_pos    = POS_W'(next_set_up(mask_ext, NUM_POS, int'(pos_q)));
    dn_pos    = POS_W'(next_set_dn(mask_ext, NUM_POS, int'(pos_q)));
  end

  assign hold_down   = hold_plus_q ? ~lvl[KEY_PLUS] : ~lvl[KEY_MINUS];
  assign timeout_hit = (IDLE_TIMEOUT != 0) && (act == ACT_NONE) &&
                       (idle_cnt_q == ICW'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edit_q      <= 1'b0;
      screen_q    <= '0;
      pos_q       <= '0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      hold_st_q   <= K_IDLE;
      hold_plus_q <= 1'b1;
      hold_cnt_q  <= '0;
      idle_cnt_q  <= '0;
    end else begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;

      if (!edit_q || act != ACT_NONE) idle_cnt_q <= '0;
      else                            idle_cnt_q <= idle_cnt_q + 1'b1;

      if (!edit_q) begin
        hold_st_q <= K_IDLE;
        case (act)
          ACT_EDIT: begin
            if (mask_act != '0) begin
              edit_q <= 1'b1;
              pos_q  <= first_pos;
            end
          end
          ACT_PLUS:  screen_q <= (screen_q == SCR_W'(NUM_SCREENS - 1)) ? '0 : screen_q + 1'b1;
          ACT_MINUS: screen_q <= (screen_q == '0) ? SCR_W'(NUM_SCREENS - 1) : screen_q - 1'b1;
          default: ;
        endcase
      end else if (act == ACT_EDIT || timeout_hit) begin
        // Leaving edit mode cancels any hold in progress; no strobe this cycle.
        edit_q    <= 1'b0;
        hold_st_q <= K_IDLE;
      end else begin
        // Cursor move wins; otherwise re-align if the mask no longer covers it.
        if (act == ACT_SWI)       pos_q <= bus.swi_reverse ? dn_pos : up_pos;
        else if (!mask_act[pos_q]) pos_q <= up_pos;

        case (hold_st_q)
          K_IDLE: begin
            if (act == ACT_PLUS || act == ACT_MINUS) begin
              inc_q       <= (act == ACT_PLUS);
              dec_q       <= (act == ACT_MINUS);
              hold_plus_q <= (act == ACT_PLUS);
              hold_cnt_q  <= '0;
              hold_st_q   <= K_HELD;
            end
          end
          K_HELD: begin
            if (!hold_down) begin
              hold_st_q <= K_IDLE;
            end else if (hold_cnt_q == HCW'(HOLD_CYCLES - 1)) begin
              inc_q      <= hold_plus_q;
              dec_q      <= ~hold_plus_q;
              hold_cnt_q <= '0;
              hold_st_q  <= K_REPEAT;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          K_REPEAT: begin
            if (!hold_down) begin
              hold_st_q <= K_IDLE;
            end else if (hold_cnt_q == HCW'(REPEAT_CYCLES - 1)) begin
              inc_q      <= hold_plus_q;
              dec_q      <= ~hold_plus_q;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          default: hold_st_q <= K_IDLE;
        endcase
      end
    end
  end

  assign bus.edit_mode = edit_q;
  assign bus.screen    = screen_q;
  assign bus.edit_pos  = pos_q;
  assign bus.inc_pulse = inc_q;
  assign bus.dec_pulse = dec_q;

endmodule

// File: tb/tb_keys_ctrl.sv
// Directed bench for keys_ctrl (DEB_CYCLES=2, HOLD_CYCLES=8, REPEAT_CYCLES=3,
// IDLE_TIMEOUT=20, default masks). Inputs change and outputs are sampled on
// the falling clock edge. A raw key change at falling edge N0 reaches the
// filtered level at rising edge 4 and the registered outputs at rising edge 5,
// i.e. it is visible at falling edge N5.
module tb_keys_ctrl;
  import keys_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keys_n;
  int         checks   = 0;
  int         failures = 0;
  int         inc_cnt  = 0;
  int         dec_cnt  = 0;
  int         both_cnt = 0;
  int         base_inc;
  int         base_dec;
  int         exp_fwd [4] = '{3, 4, 2, 3};
  int         exp_12h [5] = '{2, 3, 4, 5, 7};

  keys_ctrl_if #(.SCR_W(2), .POS_W(3)) bus ();

  assign bus.KeyPlus  = keys_n[KEY_PLUS];
  assign bus.KeyMinus = keys_n[KEY_MINUS];
  assign bus.KeyEdit  = keys_n[KEY_EDIT];
  assign bus.KeySwi   = keys_n[KEY_SWI];

  keys_ctrl #(
    .NUM_SCREENS   (3),
    .NUM_POS       (8),
    .DEB_CYCLES    (2),
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (3),
    .IDLE_TIMEOUT  (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.inc_pulse === 1'b1) inc_cnt <= inc_cnt + 1;
    if (bus.dec_pulse === 1'b1) dec_cnt <= dec_cnt + 1;
    if (bus.inc_pulse === 1'b1 && bus.dec_pulse === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Press key k for low_cyc cycles, release, then let it settle.
  task automatic press(input int k, input int low_cyc);
    keys_n[k] = 1'b0;
    repeat (low_cyc) @(negedge clk);
    keys_n[k] = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    keys_n          = 4'hF;
    reset           = 1'b1;
    bus.mode12t24   = 1'b0;
    bus.swi_reverse = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_edit_mode", 32'(bus.edit_mode), 0);
    chk("rst_screen",    32'(bus.screen),    0);
    chk("rst_edit_pos",  32'(bus.edit_pos),  0);
    chk("rst_inc",       32'(bus.inc_pulse), 0);
    chk("rst_dec",       32'(bus.dec_pulse), 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Screen stepping in normal mode
    keys_n[KEY_PLUS] = 1'b0;
    @(negedge clk);
    keys_n[KEY_PLUS] = 1'b1;
    repeat (8) @(negedge clk);
    chk("glitch_screen", 32'(bus.screen), 0);
    press(KEY_PLUS, 6);  chk("plus_screen1",   32'(bus.screen), 1);
    press(KEY_PLUS, 6);  chk("plus_screen2",   32'(bus.screen), 2);
    press(KEY_PLUS, 6);  chk("plus_wrap0",     32'(bus.screen), 0);
    press(KEY_MINUS, 6); chk("minus_wrap2",    32'(bus.screen), 2);
    press(KEY_MINUS, 6); chk("minus_screen1",  32'(bus.screen), 1);
    chk("normal_no_strobe", 32'(inc_cnt + dec_cnt), 0);

    // Cursor on screen 1 (mask positions 2,3,4)
    press(KEY_EDIT, 6);
    chk("s1_edit_on",  32'(bus.edit_mode), 1);
    chk("s1_pos_init", 32'(bus.edit_pos),  2);
    for (int i = 0; i < 4; i++) begin
      press(KEY_SWI, 6);
      chk($sformatf("s1_swi_fwd%0d", i), 32'(bus.edit_pos), 32'(exp_fwd[i]));
    end
    bus.swi_reverse = 1'b1;
    press(KEY_SWI, 6);
    chk("s1_swi_rev", 32'(bus.edit_pos), 2);
    bus.swi_reverse = 1'b0;
    press(KEY_EDIT, 6);
    chk("s1_edit_off",  32'(bus.edit_mode), 0);
    chk("s1_screen",    32'(bus.screen),    1);

    // Screen 0 in 12 h layout, then mask change while editing
    press(KEY_MINUS, 6);
    chk("s0_screen", 32'(bus.screen), 0);
    bus.mode12t24 = 1'b1;
    press(KEY_EDIT, 6);
    chk("s0_edit_on",  32'(bus.edit_mode), 1);
    chk("s0_pos_init", 32'(bus.edit_pos),  0);
    for (int i = 0; i < 5; i++) begin
      press(KEY_SWI, 6);
      chk($sformatf("s0_12h_swi%0d", i), 32'(bus.edit_pos), 32'(exp_12h[i]));
    end
    bus.mode12t24 = 1'b0;
    chk("snap_same_cycle", 32'(bus.edit_pos), 7);
    @(negedge clk);
    chk("snap_next_cycle", 32'(bus.edit_pos), 0);
    press(KEY_EDIT, 6);
    chk("s0_edit_off", 32'(bus.edit_mode), 0);
    press(KEY_EDIT, 6);
    chk("hold_edit_on", 32'(bus.edit_mode), 1);

    // Hold-to-repeat: filtered low for 20 cycles
    base_inc = inc_cnt;
    base_dec = dec_cnt;
    keys_n[KEY_PLUS] = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      chk($sformatf("hold_inc_n%0d", i), 32'(bus.inc_pulse),
          32'((i == 5) || (i == 13) || (i == 16) || (i == 19) || (i == 22)));
      if (i == 20) keys_n[KEY_PLUS] = 1'b1;
    end
    chk("hold_inc_count", 32'(inc_cnt - base_inc), 5);
    chk("hold_no_dec",    32'(dec_cnt - base_dec), 0);
    chk("hold_timed_out", 32'(bus.edit_mode),      0);

    // Edit and Plus pressed in the same cycle
    base_inc = inc_cnt;
    keys_n[KEY_EDIT] = 1'b0;
    keys_n[KEY_PLUS] = 1'b0;
    repeat (6) @(negedge clk);
    keys_n[KEY_EDIT] = 1'b1;
    keys_n[KEY_PLUS] = 1'b1;
    repeat (6) @(negedge clk);
    chk("dual_edit_on", 32'(bus.edit_mode),      1);
    chk("dual_screen",  32'(bus.screen),         0);
    chk("dual_no_inc",  32'(inc_cnt - base_inc), 0);
    press(KEY_EDIT, 6);
    chk("dual_edit_off", 32'(bus.edit_mode), 0);

    // Minus while Plus held is locked out
    keys_n[KEY_PLUS] = 1'b0;
    repeat (8) @(negedge clk);
    chk("lock_plus_screen", 32'(bus.screen), 1);
    keys_n[KEY_MINUS] = 1'b0;
    repeat (8) @(negedge clk);
    keys_n[KEY_MINUS] = 1'b1;
    keys_n[KEY_PLUS]  = 1'b1;
    repeat (8) @(negedge clk);
    chk("lock_minus_ignored", 32'(bus.screen), 1);

    // Idle timeout: edit visible at N5, cleared 20 cycles later at N25
    keys_n[KEY_EDIT] = 1'b0;
    repeat (6) @(negedge clk);
    keys_n[KEY_EDIT] = 1'b1;
    repeat (18) @(negedge clk);
    chk("timeout_before", 32'(bus.edit_mode), 1);
    @(negedge clk);
    chk("timeout_after",  32'(bus.edit_mode), 0);
    repeat (4) @(negedge clk);

    // Reset in the middle of a repeat hold
    press(KEY_EDIT, 6);
    chk("rpt_edit_on", 32'(bus.edit_mode), 1);
    base_inc = inc_cnt;
    keys_n[KEY_PLUS] = 1'b0;
    repeat (14) @(negedge clk);
    chk("rpt_two_strobes", 32'(inc_cnt - base_inc), 2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_edit",   32'(bus.edit_mode), 0);
    chk("mid_rst_screen", 32'(bus.screen),    0);
    chk("mid_rst_pos",    32'(bus.edit_pos),  0);
    chk("mid_rst_inc",    32'(bus.inc_pulse), 0);
    chk("mid_rst_dec",    32'(bus.dec_pulse), 0);
    @(negedge clk);
    reset = 1'b0;
    base_inc = inc_cnt;
    repeat (20) @(negedge clk);
    chk("post_rst_no_inc",    32'(inc_cnt - base_inc), 0);
    chk("post_rst_screen",    32'(bus.screen),         0);
    keys_n[KEY_PLUS] = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_release",   32'(bus.screen),         0);
    press(KEY_PLUS, 6);
    chk("post_rst_repress",   32'(bus.screen),         1);
    chk("post_rst_edit",      32'(bus.edit_mode),      0);
    chk("never_both_strobes", 32'(both_cnt),           0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
